// File: rtl/y_mul_div_if.sv
// Start/busy/done handshake and HI/LO result bundle for the y_mul_div unit.
interface y_mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz;

  modport master (output start, op, a, b, input busy, done, hi, lo, dz);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, dz);
endinterface

// File: rtl/y_mul_div.sv
// Iterative MULU/MUL/DIVU/DIV unit with MIPS-style HI/LO results.
// Optional macro YMULDIV_EARLY_TERM_EN: multiplies stop after the last set multiplier bit.
module y_mul_div #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  y_mul_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         op_r;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mrem;
  logic [CW-1:0]      cnt;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               dz_r;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               b_zero;
  logic [2*WIDTH:0]   mul_next;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH:0]   div_next;
  logic               last_step;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   q_s;
  logic [WIDTH-1:0]   r_s;

  always_comb begin
    a_neg  = bus.op[0] & bus.a[WIDTH-1];
    b_neg  = bus.op[0] & bus.b[WIDTH-1];
    a_mag  = a_neg ? -bus.a : bus.a;
    b_mag  = b_neg ? -bus.b : bus.b;
    b_zero = (bus.b == '0);

    mul_next = acc + {1'b0, (mrem[0] ? mcand : {(2*WIDTH){1'b0}})};

    // Restoring step: a borrow out of the trial subtract means keep the old remainder.
    trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mcand[WIDTH-1:0]};
    div_next = trial[WIDTH] ? {acc[2*WIDTH-1:0], 1'b0}
                            : {trial, acc[WIDTH-2:0], 1'b1};

`ifdef YMULDIV_EARLY_TERM_EN
    last_step = (cnt == LAST) || (!op_r[1] && (mrem[WIDTH-1:1] == '0));
`else
    last_step = (cnt == LAST);
`endif

    prod_s = neg_res ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    q_s    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_s    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_r     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mrem     <= '0;
      cnt      <= '0;
      done_r   <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      dz_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r     <= bus.op;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            cnt      <= '0;
            mrem     <= b_mag;
            div_zero <= bus.op[1] & b_zero;
            if (bus.op[1]) begin
              mcand <= {{WIDTH{1'b0}}, b_mag};
              // A zero divisor skips RUN; the raw dividend is parked where FIX reads hi.
              acc   <= b_zero ? {1'b0, bus.a, {WIDTH{1'b0}}} : {{(WIDTH+1){1'b0}}, a_mag};
              state <= b_zero ? FIX : RUN;
            end else begin
              mcand <= {{WIDTH{1'b0}}, a_mag};
              acc   <= '0;
`ifdef YMULDIV_EARLY_TERM_EN
              state <= b_zero ? FIX : RUN;
`else
              state <= RUN;
`endif
            end
          end
        end
        RUN: begin
          acc   <= op_r[1] ? div_next : mul_next;
          mcand <= op_r[1] ? mcand : {mcand[2*WIDTH-2:0], 1'b0};
          mrem  <= {1'b0, mrem[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (last_step) state <= FIX;
        end
        FIX: begin
          done_r <= 1'b1;
          state  <= IDLE;
          if (div_zero) begin
            hi_r <= acc[2*WIDTH-1:WIDTH];
            lo_r <= '1;
            dz_r <= 1'b1;
          end else if (op_r[1]) begin
            hi_r <= r_s;
            lo_r <= q_s;
            dz_r <= 1'b0;
          end else begin
            hi_r <= prod_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_s[WIDTH-1:0];
            dz_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.dz   = dz_r;
endmodule
